// File: rtl/cfg_reg_bank_pkg.sv
// cfg_reg_bank shared constants and counter-width helpers.
// Imported by the channel and the top-level bank.
package cfg_reg_bank_pkg;

  localparam int BYTE_W = 8;

  localparam int N_CH_MIN = 1;
  localparam int N_CH_MAX = 32;
  localparam int BYTES_MIN = 1;
  localparam int BYTES_MAX = 4;
  localparam int TIMEOUT_MIN = 1;
  localparam int TIMEOUT_MAX = 65535;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // bits needed to hold values 0..maxval, never less than 1
  function automatic int cnt_w(input int maxval);
    return (maxval < 2) ? 1 : clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/cfg_reg_chan.sv
// One config channel: byte assembly, partial-write timeout,
// optional self-clearing value and MSB-first readback.
module cfg_reg_chan
  import cfg_reg_bank_pkg::*;
#(
  parameter int BYTES = 1,
  parameter bit PULSE = 1'b0,
  parameter int TIMEOUT = 255,
  localparam int RW = BYTE_W * BYTES
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [7:0]    data,
  input  logic          valid,
  input  logic          rdreq,
  output logic          have_msg,
  output logic [7:0]    slave_data,
  output logic [7:0]    len,
  output logic [RW-1:0] reg_q,
  output logic          commit_strb
);

  localparam int SW = (BYTES > 1) ? RW - BYTE_W : 1;
  localparam int WW = cnt_w(BYTES - 1);
  localparam int IW = cnt_w(TIMEOUT);
  localparam int CW = cnt_w(BYTES);

  localparam logic [WW-1:0] WR_LAST = WW'(BYTES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RD_FULL = CW'(BYTES);
  localparam logic [CW-1:0] RD_MSB = CW'(BYTES - 1);

  logic [SW-1:0] shadow;
  logic [WW-1:0] wr_cnt;
  logic [IW-1:0] idle;
  logic [RW-1:0] snap;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] sel;

  logic [SW+7:0] full;
  logic [RW-1:0] commit_val;
  logic          commit;

  assign full = {shadow, data};
  assign commit_val = full[RW-1:0];
  assign commit = valid && (wr_cnt == WR_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shadow <= '0;
      wr_cnt <= '0;
      idle <= '0;
    end else if (valid) begin
      idle <= '0;
      if (commit) begin
        shadow <= '0;
        wr_cnt <= '0;
      end else begin
        shadow <= full[SW-1:0];
        wr_cnt <= wr_cnt + 1'b1;
      end
    end else if (wr_cnt != '0) begin
      // a stalled partial write is dropped, never committed
      if (idle == IDLE_LAST) begin
        shadow <= '0;
        wr_cnt <= '0;
        idle <= '0;
      end else begin
        idle <= idle + 1'b1;
      end
    end else begin
      idle <= '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      reg_q <= '0;
      commit_strb <= 1'b0;
    end else begin
      commit_strb <= commit;
      if (commit) begin
        reg_q <= commit_val;
      end else if (PULSE) begin
        reg_q <= '0;
      end
    end
  end

  // commit takes priority over a concurrent rdreq
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      snap <= '0;
      rd_cnt <= '0;
    end else if (commit) begin
      snap <= commit_val;
      rd_cnt <= RD_FULL;
    end else if (rdreq && (rd_cnt != '0)) begin
      rd_cnt <= rd_cnt - 1'b1;
    end
  end

  assign have_msg = (rd_cnt != '0);
  assign sel = have_msg ? rd_cnt - 1'b1 : RD_MSB;
  assign len = {{(8 - CW){1'b0}}, rd_cnt};

  always_comb begin
    slave_data = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (sel == CW'(b)) slave_data = snap[b*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/cfg_reg_bank.sv
// Bank of independent config register channels.
// Top level only slices the shared buses per channel.
module cfg_reg_bank
  import cfg_reg_bank_pkg::*;
#(
  parameter int N_CH = 10,
  parameter int BYTES = 1,
  parameter logic [N_CH-1:0] PULSE_MASK = '0,
  parameter int TIMEOUT = 255,
  localparam int RW = BYTE_W * BYTES
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [7:0]         master_data,
  input  logic [N_CH-1:0]    valid_bus,
  input  logic [N_CH-1:0]    rdreq_bus,
  output logic [N_CH-1:0]    have_msg_bus,
  output logic [8*N_CH-1:0]  slave_data_bus,
  output logic [8*N_CH-1:0]  len_bus,
  output logic [RW*N_CH-1:0] regs_q,
  output logic [N_CH-1:0]    commit_strb
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cfg_reg_chan #(
      .BYTES   (BYTES),
      .PULSE   (PULSE_MASK[i]),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .n_rst       (n_rst),
      .data        (master_data),
      .valid       (valid_bus[i]),
      .rdreq       (rdreq_bus[i]),
      .have_msg    (have_msg_bus[i]),
      .slave_data  (slave_data_bus[8*i +: 8]),
      .len         (len_bus[8*i +: 8]),
      .reg_q       (regs_q[RW*i +: RW]),
      .commit_strb (commit_strb[i])
    );
  end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed scoreboard bench for cfg_reg_bank.
// Two instances: single-byte with a pulse channel, two-byte with short timeout.
module tb_cfg_reg_bank;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  logic [7:0]  a_data = '0;
  logic [9:0]  a_valid = '0;
  logic [9:0]  a_rdreq = '0;
  logic [9:0]  a_have;
  logic [79:0] a_slave;
  logic [79:0] a_len;
  logic [79:0] a_regs;
  logic [9:0]  a_strb;

  logic [7:0]   b_data = '0;
  logic [9:0]   b_valid = '0;
  logic [9:0]   b_rdreq = '0;
  logic [9:0]   b_have;
  logic [79:0]  b_slave;
  logic [79:0]  b_len;
  logic [159:0] b_regs;
  logic [9:0]   b_strb;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cfg_reg_bank #(
    .N_CH       (10),
    .BYTES      (1),
    .PULSE_MASK (10'h020),
    .TIMEOUT    (255)
  ) u_a (
    .clk            (clk),
    .n_rst          (n_rst),
    .master_data    (a_data),
    .valid_bus      (a_valid),
    .rdreq_bus      (a_rdreq),
    .have_msg_bus   (a_have),
    .slave_data_bus (a_slave),
    .len_bus        (a_len),
    .regs_q         (a_regs),
    .commit_strb    (a_strb)
  );

  cfg_reg_bank #(
    .N_CH       (10),
    .BYTES      (2),
    .PULSE_MASK (10'h000),
    .TIMEOUT    (4)
  ) u_b (
    .clk            (clk),
    .n_rst          (n_rst),
    .master_data    (b_data),
    .valid_bus      (b_valid),
    .rdreq_bus      (b_rdreq),
    .have_msg_bus   (b_have),
    .slave_data_bus (b_slave),
    .len_bus        (b_len),
    .regs_q         (b_regs),
    .commit_strb    (b_strb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty got=%h want=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s got=%h want=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic b_wr(input int ch, input logic [7:0] d);
    b_valid = '0;
    b_valid[ch] = 1'b1;
    b_data = d;
    tick();
    b_valid = '0;
  endtask

  initial begin
    // reset state while n_rst is held low
    #3;
    want("rst_a_regs", 64'h0);
    want("rst_a_have", 64'h0);
    want("rst_b_regs", 64'h0);
    want("rst_b_len", 64'h0);
    want("rst_b_strb", 64'h0);
    chk(a_regs[63:0]);
    chk({54'h0, a_have});
    chk(b_regs[63:0]);
    chk(b_len[63:0]);
    chk({54'h0, b_strb});
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    tick();

    // single-byte commit and readback
    a_valid[0] = 1'b1;
    a_data = 8'h5A;
    want("a0_q", 64'h5A);
    want("a0_strb", 64'h1);
    want("a0_have", 64'h1);
    want("a0_len", 64'h1);
    want("a0_slave", 64'h5A);
    tick();
    a_valid = '0;
    chk({56'h0, a_regs[7:0]});
    chk({63'h0, a_strb[0]});
    chk({63'h0, a_have[0]});
    chk({56'h0, a_len[7:0]});
    chk({56'h0, a_slave[7:0]});
    want("a0_strb_1cyc", 64'h0);
    want("a0_q_hold", 64'h5A);
    tick();
    chk({63'h0, a_strb[0]});
    chk({56'h0, a_regs[7:0]});
    a_rdreq[0] = 1'b1;
    want("a0_have_rd", 64'h0);
    want("a0_len_rd", 64'h0);
    want("a0_slave_rd", 64'h5A);
    tick();
    a_rdreq = '0;
    chk({63'h0, a_have[0]});
    chk({56'h0, a_len[7:0]});
    chk({56'h0, a_slave[7:0]});

    // simultaneous commits on two channels
    a_valid = 10'b0010000100;
    a_data = 8'h33;
    want("a2_q", 64'h33);
    want("a7_q", 64'h33);
    want("a_strb_27", 64'h084);
    tick();
    a_valid = '0;
    chk({56'h0, a_regs[23:16]});
    chk({56'h0, a_regs[63:56]});
    chk({54'h0, a_strb});

    // pulse channel: one-cycle value, readback keeps it
    a_valid[5] = 1'b1;
    a_data = 8'h01;
    want("a5_q_set", 64'h01);
    tick();
    a_valid = '0;
    chk({56'h0, a_regs[47:40]});
    want("a5_q_clr", 64'h0);
    want("a5_have", 64'h1);
    want("a5_slave", 64'h01);
    tick();
    chk({56'h0, a_regs[47:40]});
    chk({63'h0, a_have[5]});
    chk({56'h0, a_slave[47:40]});

    // pulse back-to-back
    a_valid[5] = 1'b1;
    a_data = 8'h07;
    want("a5_bb1", 64'h07);
    tick();
    chk({56'h0, a_regs[47:40]});
    a_data = 8'h09;
    want("a5_bb2", 64'h09);
    tick();
    a_valid = '0;
    chk({56'h0, a_regs[47:40]});
    want("a5_bb_clr", 64'h0);
    tick();
    chk({56'h0, a_regs[47:40]});

    // two-byte assembly on channel 3
    want("b3_partial_strb", 64'h0);
    want("b3_partial_q", 64'h0);
    b_wr(3, 8'h12);
    chk({63'h0, b_strb[3]});
    chk({48'h0, b_regs[63:48]});
    want("b3_q", 64'h1234);
    want("b3_strb", 64'h1);
    want("b3_slave_msb", 64'h12);
    want("b3_len2", 64'h2);
    b_wr(3, 8'h34);
    chk({48'h0, b_regs[63:48]});
    chk({63'h0, b_strb[3]});
    chk({56'h0, b_slave[31:24]});
    chk({56'h0, b_len[31:24]});
    b_rdreq[3] = 1'b1;
    want("b3_slave_lsb", 64'h34);
    want("b3_len1", 64'h1);
    tick();
    chk({56'h0, b_slave[31:24]});
    chk({56'h0, b_len[31:24]});
    want("b3_have_done", 64'h0);
    want("b3_len0", 64'h0);
    tick();
    b_rdreq = '0;
    chk({63'h0, b_have[3]});
    chk({56'h0, b_len[31:24]});

    // timeout after exactly 4 idle cycles discards 0xAA
    b_wr(0, 8'hAA);
    repeat (4) tick();
    want("b0_to_strb", 64'h0);
    want("b0_to_q", 64'h0);
    chk({63'h0, b_strb[0]});
    chk({48'h0, b_regs[15:0]});
    b_wr(0, 8'h01);
    want("b0_q", 64'h0102);
    want("b0_strb", 64'h1);
    b_wr(0, 8'h02);
    chk({48'h0, b_regs[15:0]});
    chk({63'h0, b_strb[0]});

    // 3 idle cycles is still within the window
    b_wr(2, 8'hC0);
    repeat (3) tick();
    want("b2_no_to", 64'hC00D);
    b_wr(2, 8'h0D);
    chk({48'h0, b_regs[47:32]});

    // commit wins over a concurrent rdreq
    b_wr(1, 8'h11);
    b_wr(1, 8'h22);
    b_rdreq[1] = 1'b1;
    want("b1_mid_len", 64'h1);
    want("b1_mid_slave", 64'h22);
    tick();
    b_rdreq = '0;
    chk({56'h0, b_len[15:8]});
    chk({56'h0, b_slave[15:8]});
    b_wr(1, 8'h33);
    b_valid[1] = 1'b1;
    b_data = 8'h44;
    b_rdreq[1] = 1'b1;
    want("b1_race_len", 64'h2);
    want("b1_race_slave", 64'h33);
    want("b1_race_q", 64'h3344);
    tick();
    b_valid = '0;
    b_rdreq = '0;
    chk({56'h0, b_len[15:8]});
    chk({56'h0, b_slave[15:8]});
    chk({48'h0, b_regs[31:16]});

    // reset mid-assembly
    b_wr(4, 8'h99);
    n_rst = 1'b0;
    #2;
    want("rst2_regs_lo", 64'h0);
    want("rst2_regs_hi", 64'h0);
    want("rst2_have", 64'h0);
    want("rst2_len", 64'h0);
    want("rst2_slave", 64'h0);
    chk(b_regs[63:0]);
    chk(b_regs[127:64]);
    chk({54'h0, b_have});
    chk(b_len[63:0]);
    chk(b_slave[63:0]);
    n_rst = 1'b1;
    tick();
    b_wr(4, 8'hBE);
    want("b4_q", 64'hBEEF);
    want("b4_slave", 64'hBE);
    b_wr(4, 8'hEF);
    chk({48'h0, b_regs[79:64]});
    chk({56'h0, b_slave[39:32]});

    if (sb.size() != 0) begin
      bad++;
      $error("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_reg_bank.md
CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
Parameters (name, default, meaning):
REQ-001 N_CH, 10, number of register channels, range 1..32.
REQ-002 BYTES, 1, bytes per register, range 1..4; register width RW = 8*BYTES.
REQ-003 PULSE_MASK, 0, N_CH-bit mask; bit i=1 makes channel i self-clearing.
REQ-004 TIMEOUT, 255, idle cycles after which a partial multi-byte write is discarded, range 1..65535.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 n_rst  in  1  reset, asynchronous, active-low.
REQ-007 master_data  in  8  write byte, shared by all channels.
REQ-008 valid_bus  in  N_CH  bit i = master_data valid for channel i this cycle.
REQ-009 rdreq_bus  in  N_CH  bit i = consume current readback byte of channel i.
REQ-010 have_msg_bus  out  N_CH  bit i = channel i has readback bytes pending.
REQ-011 slave_data_bus  out  8*N_CH  byte i = current readback byte of channel i.
REQ-012 len_bus  out  8*N_CH  byte i = readback bytes remaining in channel i.
REQ-013 regs_q  out  RW*N_CH  field i = committed register value of channel i.
REQ-014 commit_strb  out  N_CH  bit i = one-cycle pulse when channel i commits.

Function
REQ-015 Each channel SHALL run independently; simultaneous valids on several channels SHALL all be accepted in the same cycle.
REQ-016 Write assembly: valid with wr_cnt < BYTES-1 SHALL store the byte in a shadow register (MSB first) and increment wr_cnt.
REQ-017 Valid with wr_cnt = BYTES-1 SHALL, on that edge, load regs_q with {shadow, master_data}, reset wr_cnt to 0, and assert commit_strb for the following cycle only.
REQ-018 With BYTES=1 every valid SHALL commit immediately; latency valid -> regs_q updated = 1 cycle.
REQ-019 Timeout: while wr_cnt != 0, an idle counter SHALL count cycles without valid; reaching TIMEOUT SHALL reset wr_cnt to 0 and discard the shadow, regs_q unchanged, no commit_strb.
REQ-020 Any valid SHALL clear the idle counter; the counter SHALL be held at 0 while wr_cnt = 0.
REQ-021 Pulse mode (PULSE_MASK[i]=1): regs_q field i SHALL return to 0 one cycle after commit; back-to-back commits SHALL each produce a one-cycle value.
REQ-022 Readback: a commit SHALL load a snapshot of the new value, set rd_cnt = BYTES and raise have_msg on the cycle after the commit edge.
REQ-023 slave_data SHALL present snapshot byte (rd_cnt-1), i.e. MSB first; len SHALL equal rd_cnt zero-extended to 8 bits.
REQ-024 rdreq while have_msg=1 SHALL decrement rd_cnt at the next edge; have_msg SHALL drop when rd_cnt reaches 0.
REQ-025 rdreq while have_msg=0 SHALL be ignored; slave_data SHALL then hold the last snapshot MSB byte and len SHALL be 0.
REQ-026 Commit and rdreq in the same cycle: commit SHALL win; snapshot reloaded, rd_cnt = BYTES.
REQ-027 Pulse-mode channels SHALL read back the committed value, not the cleared value.

Reset
REQ-028 n_rst low SHALL immediately clear regs_q, shadow, wr_cnt, idle counter, snapshot, rd_cnt, have_msg_bus and commit_strb to 0.
REQ-029 Reset mid-assembly or mid-readback SHALL discard all partial state; first valid after release starts a new register at byte 0.

Structure
REQ-030 Shared package cfg_reg_bank_pkg SHALL hold the byte-width constant, parameter range limits and a clog2 function for counter widths.
REQ-031 One sub-module cfg_reg_chan (one channel: assembly, timeout, pulse, readback) SHALL be instantiated N_CH times by generate loop; top-level SHALL only slice buses.

Verification
REQ-032 BYTES=1, valid_bus[0] with 0x5A -> regs_q[7:0]=0x5A next cycle, commit_strb[0] one cycle, have_msg[0]=1, len=1, slave_data=0x5A; rdreq -> have_msg=0.
REQ-033 BYTES=2, bytes 0x12 then 0x34 on ch 3 -> field 3 = 0x1234; readback 0x12 (len 2), then 0x34 (len 1), then have_msg=0.
REQ-034 BYTES=2, TIMEOUT=4, single byte 0xAA then 4 idle cycles, then 0x01,0x02 -> value 0x0102, no commit for 0xAA.
REQ-035 PULSE_MASK bit 5 set, write 0x01 on ch 5 -> regs_q field 5 high exactly one cycle; readback still returns 0x01.
REQ-036 BYTES=2, commit on ch 1 in same cycle as rdreq[1] during pending readback -> rd_cnt=2, new MSB presented.
REQ-037 n_rst pulse after first of two bytes -> all outputs 0; next two bytes 0xBE,0xEF commit 0xBEEF.
